alu_exec_sequencer: RTL and testbench

//  Execution stage directly downstream of the op decoder: consumes one-hot add/sub/mul/div enables

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter_core.sv | 102 ++++++++++
 rtl/alu_exec_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared types and constants for the ALU execution sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    localparam logic [3:0] c_OP_ADD = 4'b0001;
    localparam logic [3:0] c_OP_SUB = 4'b0010;
    localparam logic [3:0] c_OP_MUL = 4'b0100;
    localparam logic [3:0] c_OP_DIV = 4'b1000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDSUB = 3'd1,
        MUL    = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } state_e;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_core.sv
`default_nettype none
// ============================================================================
// Module  : alu_iter_core
// Brief   : Bit-serial unsigned shift-add multiplier / restoring divider.
// Revision: 1.0 - initial release
// ============================================================================
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 busy_q, busy_d;
    logic                 mode_q, mode_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]     y_q, y_d;
    logic [WIDTH-1:0]     rem_q, rem_d;

    logic [WIDTH:0]       w_shift;
    logic                 w_neg;
    logic [WIDTH-1:0]     w_sub;

    // Partial remainder is always below the divisor, so the low WIDTH bits of
    // the trial difference hold the full value whenever it is non-negative.
    assign w_shift = {rem_q, y_q[WIDTH-1]};
    assign w_neg   = w_shift < {1'b0, x_q[WIDTH-1:0]};
    assign w_sub   = w_shift[WIDTH-1:0] - x_q[WIDTH-1:0];

    always_comb begin
        busy_d = busy_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        rem_d  = rem_q;
        if (start_i) begin
            busy_d = 1'b1;
            mode_d = mode_i;
            cnt_d  = '0;
            acc_d  = '0;
            rem_d  = '0;
            x_d    = {{WIDTH{1'b0}}, (mode_i ? b_i : a_i)};
            y_d    = mode_i ? a_i : b_i;
        end else if (busy_q) begin
            if (cnt_q == CW'(WIDTH)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (mode_q) begin
                    rem_d = w_neg ? w_shift[WIDTH-1:0] : w_sub;
                    y_d   = {y_q[WIDTH-2:0], ~w_neg};
                end else begin
                    if (y_q[0]) begin
                        acc_d = acc_q + x_q;
                    end
                    x_d = x_q << 1;
                    y_d = y_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            x_q    <= x_d;
            y_q    <= y_d;
            rem_q  <= rem_d;
        end
    end

    assign done_o   = busy_q && (cnt_q == CW'(WIDTH));
    assign result_o = mode_q ? {rem_q, y_q} : acc_q;

endmodule
`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_exec_sequencer
// Brief   : Single-issue add/sub/mul/div execution stage with valid/ready I/O.
// Revision: 1.0 - initial release
// ============================================================================
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 add_en,
    input  logic                 sub_en,
    input  logic                 mul_en,
    input  logic                 div_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 div_by_zero,
    output logic                 op_err
);

    state_e               state_q, state_d;
    logic                 stage_q, stage_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 dbz_q, dbz_d;
    logic                 err_q, err_d;

    logic [3:0]           w_op;
    logic                 w_accept;
    logic                 w_start;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_core_done;
    logic [2*WIDTH-1:0]   w_core_result;

    assign w_op     = {div_en, mul_en, sub_en, add_en};
    assign w_accept = in_valid && (state_q == IDLE);
    // Divide by zero never enters the iterative core; it resolves in ADDSUB.
    assign w_start  = w_accept && ((w_op == c_OP_MUL) || ((w_op == c_OP_DIV) && (b != '0)));
    assign w_sum    = {1'b0, a_q} + {1'b0, b_q};
    assign w_diff   = a_q - b_q;

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (w_start),
        .mode_i   (w_op == c_OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .done_o   (w_core_done),
        .result_o (w_core_result)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = w_op;
                    stage_d  = 1'b0;
                    result_d = '0;
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                    err_d    = 1'b0;
                    if (w_op == c_OP_MUL) begin
                        state_d = MUL;
                    end else if ((w_op == c_OP_DIV) && (b != '0)) begin
                        state_d = DIV;
                    end else begin
                        state_d = ADDSUB;
                    end
                end
            end
            ADDSUB: begin
                // Two cycles here so single-cycle ops match the k+2 result timing.
                if (!stage_q) begin
                    stage_d = 1'b1;
                end else begin
                    state_d = DONE;
                    if (!is_onehot4(op_q)) begin
                        err_d = 1'b1;
                    end else if (op_q == c_OP_ADD) begin
                        result_d = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                        carry_d  = w_sum[WIDTH];
                    end else if (op_q == c_OP_SUB) begin
                        result_d = {{WIDTH{1'b0}}, w_diff};
                        carry_d  = (a_q < b_q);
                    end else begin
                        result_d = {a_q, {WIDTH{1'b1}}};
                        dbz_d    = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                if (w_core_done) begin
                    state_d  = DONE;
                    result_d = w_core_result;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            stage_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
            err_q    <= err_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = result_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;
    assign op_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_exec_sequencer
// Brief   : Self-checking bench: directed literal cases plus randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_exec_sequencer;

    localparam int W = 8;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        z;
        logic        e;
        logic [3:0]  lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    en = '0;
    logic          in_ready, out_valid, carry, div_by_zero, op_err;
    logic [2*W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    int   m_phase = 0;
    int   m_wait  = 0;
    exp_t m_exp   = '0;

    always #5 clk = ~clk;

    alu_exec_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .add_en      (en[0]),
        .sub_en      (en[1]),
        .mul_en      (en[2]),
        .div_en      (en[3]),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry       (carry),
        .div_by_zero (div_by_zero),
        .op_err      (op_err)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_op(input logic [7:0] x, input logic [7:0] y, input logic [3:0] e);
        exp_t o;
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        o = '0;
        o.lat = 4'd2;
        case (e)
            4'b0001: begin
                o.r = 16'((xi + yi) % 256);
                o.c = (xi + yi) > 255;
            end
            4'b0010: begin
                o.r = 16'((xi - yi + 256) % 256);
                o.c = xi < yi;
            end
            4'b0100: begin
                o.r   = 16'(xi * yi);
                o.lat = 4'd9;
            end
            4'b1000: begin
                if (yi == 0) begin
                    o.r = {x, 8'hFF};
                    o.z = 1'b1;
                end else begin
                    o.r   = 16'((xi % yi) * 256 + xi / yi);
                    o.lat = 4'd9;
                end
            end
            default: o.e = 1'b1;
        endcase
        return o;
    endfunction

    // Transaction-level model: idle -> busy for the op's latency -> done until taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_wait  <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   <= ref_op(a, b, en);
                    m_wait  <= int'(ref_op(a, b, en).lat);
                    m_phase <= 1;
                end
                1: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) m_phase <= 2;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            cmp("in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
            cmp("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
            if (m_phase == 2) begin
                cmp("result", {16'b0, result}, {16'b0, m_exp.r});
                cmp("carry", {31'b0, carry}, {31'b0, m_exp.c});
                cmp("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_exp.z});
                cmp("op_err", {31'b0, op_err}, {31'b0, m_exp.e});
            end else if (m_phase == 1) begin
                cmp("flags_busy", {29'b0, carry, div_by_zero, op_err}, 32'd0);
            end
        end
    end

    task automatic run_op(input logic [7:0] ra, input logic [7:0] rb, input logic [3:0] re,
                          input int hold, input logic [15:0] xr, input logic xc,
                          input logic xz, input logic xe, input int xlat);
        int  lat;
        bit  seen;
        @(posedge clk); #2;
        in_valid = 1'b1; a = ra; b = rb; en = re; out_ready = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); en = 4'($urandom);
        lat = -1;
        seen = 1'b0;
        for (int j = 0; j < 40 && !seen; j++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = j;
            end
        end
        cmp("latency", lat, xlat);
        cmp("lit_result", {16'b0, result}, {16'b0, xr});
        cmp("lit_carry", {31'b0, carry}, {31'b0, xc});
        cmp("lit_dbz", {31'b0, div_by_zero}, {31'b0, xz});
        cmp("lit_err", {31'b0, op_err}, {31'b0, xe});
        repeat (hold) @(negedge clk);
        cmp("hold_valid", {31'b0, out_valid}, 32'd1);
        cmp("hold_result", {16'b0, result}, {16'b0, xr});
        @(posedge clk); #2; out_ready = 1'b1;
        @(posedge clk); #2; out_ready = 1'b0;
        @(negedge clk);
        cmp("drop_valid", {31'b0, out_valid}, 32'd0);
        cmp("rise_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_in_ready", {31'b0, in_ready}, 32'd1);
        cmp("rst_out_valid", {31'b0, out_valid}, 32'd0);
        cmp("rst_result", {16'b0, result}, 32'd0);
        cmp("rst_flags", {29'b0, carry, div_by_zero, op_err}, 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;

        run_op(8'hFF, 8'h01, 4'b0001, 0, 16'h0000, 1'b1, 1'b0, 1'b0, 2);
        run_op(8'h03, 8'h05, 4'b0010, 0, 16'h00FE, 1'b1, 1'b0, 1'b0, 2);
        run_op(8'h05, 8'h03, 4'b0010, 0, 16'h0002, 1'b0, 1'b0, 1'b0, 2);
        run_op(8'hFF, 8'hFF, 4'b0100, 0, 16'hFE01, 1'b0, 1'b0, 1'b0, 9);
        run_op(8'h5A, 8'h00, 4'b0100, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 9);
        run_op(8'd200, 8'd7, 4'b1000, 0, 16'h041C, 1'b0, 1'b0, 1'b0, 9);
        run_op(8'd200, 8'd0, 4'b1000, 0, 16'hC8FF, 1'b0, 1'b1, 1'b0, 2);
        run_op(8'h03, 8'h04, 4'b0110, 5, 16'h0000, 1'b0, 1'b0, 1'b1, 2);
        run_op(8'h03, 8'h04, 4'b0000, 0, 16'h0000, 1'b0, 1'b0, 1'b1, 2);
        run_op(8'h80, 8'h7F, 4'b0001, 5, 16'h00FF, 1'b0, 1'b0, 1'b0, 2);

        for (int i = 0; i < 3000; i++) begin
            int r;
            @(posedge clk); #2;
            in_valid  = ($urandom_range(0, 1) == 1);
            a         = 8'($urandom);
            b         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            r         = int'($urandom_range(0, 9));
            en        = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #2 out_ready = 1'b0;

        // Abort a multiply in flight with reset, then confirm recovery.
        @(posedge clk); #2;
        in_valid = 1'b1; a = 8'd13; b = 8'd11; en = 4'b0100;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("abort_in_ready", {31'b0, in_ready}, 32'd1);
        cmp("abort_out_valid", {31'b0, out_valid}, 32'd0);
        cmp("abort_result", {16'b0, result}, 32'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (12) @(negedge clk);
        cmp("abort_no_output", {31'b0, out_valid}, 32'd0);
        run_op(8'h12, 8'h34, 4'b0001, 0, 16'h0046, 1'b0, 1'b0, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
